// File: rtl/trng_pkg.sv
// trng_pkg: shared constants and types for the TRNG word server.
//   TRNG_WORD_W        - width of a delivered entropy word
//   RCT_CUTOFF_DEFAULT - default repetition-count health test cutoff
//   serve_state_t      - response FSM states
package trng_pkg;

  localparam int unsigned TRNG_WORD_W        = 32;
  localparam int unsigned RCT_CUTOFF_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } serve_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: synchronous word FIFO for the TRNG word server.
//   clk, rst   - clock, synchronous active-high reset
//   push, data - write request and word; ignored when full unless popping too
//   pop        - read request; ignored when empty
//   flush      - empties the FIFO; dominates push and pop
//   head       - word at the read pointer (valid when !empty)
//   level      - post-edge occupancy, 0..DEPTH
//   full/empty - occupancy flags
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = TRNG_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_word_server.sv
// trng_word_server: responder end of the TRNG word interface.
//   clk, rst      - clock, synchronous active-high reset
//   enable        - accept entropy when high
//   ent_bit/valid - raw entropy bitstream
//   trng_request  - requester wants a word (held until trng_ready)
//   trng_ready    - one-cycle pulse qualifying trng_data
//   trng_data     - delivered word, zero while trng_ready is low
//   fifo_level    - words buffered
//   health_fail   - sticky repetition-count failure flag
//   health_clear  - clears health_fail and restarts the RCT
module trng_word_server
  import trng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEFAULT,
  parameter int unsigned DEBIAS_EN  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          ent_bit,
  input  logic                          ent_valid,
  input  logic                          trng_request,
  output logic                          trng_ready,
  output logic [TRNG_WORD_W-1:0]        trng_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  input  logic                          health_clear
);

  localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

  serve_state_t           state;
  logic                   raw_take;
  logic [RCT_W-1:0]       rct_cnt;
  logic                   rct_last;
  logic                   rct_same;
  logic                   rct_trip;
  logic                   pair_have;
  logic                   pair_first;
  logic                   acc_valid;
  logic                   acc_bit;
  logic [TRNG_WORD_W-2:0] pack_sr;
  logic [5:0]             pack_cnt;
  logic [TRNG_WORD_W-1:0] pack_word;
  logic                   pack_push;
  logic                   fifo_push;
  logic                   serve_pop;
  logic [TRNG_WORD_W-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign raw_take = ent_valid && enable && !health_fail;

  // ---------------- repetition-count test ----------------
  // rct_cnt == 0 means no bit seen since reset/clear.
  assign rct_same = (rct_cnt != '0) && (ent_bit == rct_last);
  assign rct_trip = raw_take && rct_same && (rct_cnt == RCT_W'(RCT_CUTOFF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      health_fail <= 1'b0;
      rct_cnt     <= '0;
      rct_last    <= 1'b0;
    end else if (rct_trip) begin
      health_fail <= 1'b1;
      rct_cnt     <= RCT_W'(RCT_CUTOFF);
      rct_last    <= ent_bit;
    end else if (health_clear) begin
      health_fail <= 1'b0;
      rct_cnt     <= raw_take ? RCT_W'(1) : '0;
      rct_last    <= raw_take ? ent_bit : rct_last;
    end else if (raw_take) begin
      rct_last <= ent_bit;
      rct_cnt  <= rct_same ? rct_cnt + RCT_W'(1) : RCT_W'(1);
    end
  end

  // ---------------- debias ----------------
  // Von Neumann: (1,0) -> 1, (0,1) -> 0, so the accepted bit is the first of the pair.
  always_comb begin
    acc_valid = 1'b0;
    acc_bit   = ent_bit;
    if (raw_take) begin
      if (DEBIAS_EN == 0) begin
        acc_valid = 1'b1;
      end else if (pair_have && (pair_first != ent_bit)) begin
        acc_valid = 1'b1;
        acc_bit   = pair_first;
      end
    end
  end

  // ---------------- packer ----------------
  assign pack_word = {pack_sr, acc_bit};
  assign pack_push = acc_valid && !rct_trip && (pack_cnt == 6'(TRNG_WORD_W - 1));
  assign fifo_push = pack_push && (!fifo_full || serve_pop);

  always_ff @(posedge clk) begin
    if (rst || rct_trip) begin
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
      pack_sr    <= '0;
      pack_cnt   <= '0;
    end else begin
      if (raw_take) begin
        pair_have  <= (DEBIAS_EN != 0) && !pair_have;
        pair_first <= ent_bit;
      end
      if (acc_valid) begin
        pack_sr  <= pack_word[TRNG_WORD_W-2:0];
        pack_cnt <= (pack_cnt == 6'(TRNG_WORD_W - 1)) ? '0 : pack_cnt + 6'd1;
      end
    end
  end

  // ---------------- word buffer ----------------
  trng_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TRNG_WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pack_word),
    .pop       (serve_pop),
    .flush     (rct_trip),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- response FSM ----------------
  // A trip on this edge blocks the pop; a pulse already in SERVE still finishes.
  assign serve_pop = (state == IDLE) && trng_request && !fifo_empty &&
                     !health_fail && !rct_trip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trng_ready <= 1'b0;
      trng_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (serve_pop) begin
            state      <= SERVE;
            trng_ready <= 1'b1;
            trng_data  <= fifo_head;
          end else begin
            trng_ready <= 1'b0;
            trng_data  <= '0;
          end
        end
        SERVE: begin
          state      <= IDLE;
          trng_ready <= 1'b0;
          trng_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/trng_word_server.md
Name: trng_word_server

Overview:
- Responder end of the TRNG word interface used by the ChaCha20 core for key, nonce and counter acquisition.
- Takes a raw entropy bitstream and optionally applies von Neumann debiasing.
- Runs a repetition-count health test on the raw bits, packs accepted bits into 32-bit words, and buffers the words in a small FIFO.
- Answers trng_request with one-cycle trng_ready pulses carrying trng_data.

Parameters:
FIFO_DEPTH, 4, word buffer depth (power of 2, ≥2)
RCT_CUTOFF, 32, consecutive identical raw bits that trip the health test
DEBIAS_EN, 1, 1 = von Neumann debiasing, 0 = every raw bit accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  accept entropy when high
ent_bit  in  1  raw entropy bit
ent_valid  in  1  ent_bit valid this cycle
trng_request  in  1  requester wants a word; held until trng_ready seen
trng_ready  out  1  one-cycle pulse, trng_data valid
trng_data  out  32  delivered word; zero whenever trng_ready low
fifo_level  out  $clog2(FIFO_DEPTH)+1  words buffered
health_fail  out  1  sticky RCT failure flag
health_clear  in  1  clears health_fail and resumes operation

Behaviour:
- Reset values: trng_ready 0, trng_data 0, fifo_level 0, health_fail 0. Reset also clears the packer, debias pair register, RCT counter and FSM (IDLE). Reset mid-operation aborts everything; no pulse is issued in the cycle after reset.
- Raw bit path: a raw bit is taken only when ent_valid && enable && !health_fail. With enable low, bits are ignored, packer and RCT state are held, and the FIFO is still served.
- RCT:
  - Counter tracks the run length of identical raw bits; it resets to 1 on a change.
  - When the count reaches RCT_CUTOFF, at that edge: health_fail <= 1, FIFO flushed, packer/debias cleared.
- Debias (DEBIAS_EN=1): raw bits are paired (first, second). (1,0) → 1, (0,1) → 0, 00/11 discarded. Pairs never overlap.
- Packer:
  - MSB-first: the first accepted bit lands in bit 31.
  - 6-bit count; on the 32nd bit the word is pushed and the count wraps to 0.
  - Push while FIFO full and no pop that edge: word dropped, packer continues. The source is never stalled.
  - Push and pop on the same edge with FIFO full: both occur, nothing dropped.
- Response FSM, states IDLE and SERVE:
  - IDLE → SERVE when trng_request && fifo_level≠0 && !health_fail at an edge. At that edge the head is popped into trng_data and trng_ready <= 1.
  - SERVE → IDLE unconditionally. trng_ready <= 0 and trng_data <= 0.
  - Latency: ready is high in the cycle after request is first sampled with data available.
  - Pulses are separated by ≥1 low cycle, so the requester can drop request or advance its chunk index.
  - Once a pulse is committed it completes even if request falls; the word is consumed.
  - Empty FIFO: request waits with no timeout and no error.
- Health fail:
  - Fail detection has priority over a pop at the same edge: no pop, FSM stays IDLE.
  - A pulse already in SERVE completes with its registered data.
  - While failed, no new pulses are issued.
  - health_clear: at the edge, health_fail <= 0 and the RCT counter resets. Normal operation resumes the next cycle. Clear at the same edge as a new trip: trip wins.
- fifo_level reflects post-edge occupancy; width-safe for level = FIFO_DEPTH.

Decomposition:
- Package trng_pkg: TRNG_WORD_W=32, serve-FSM state enum {IDLE, SERVE}, default RCT_CUTOFF.
- Sub-module trng_word_fifo: synchronous FIFO with push, pop, flush (flush dominates), level, full, empty.
- Debias, packer, RCT and FSM stay in the top module.

Test Plan:
1. DEBIAS_EN=1, raw 01,10 repeated 32 pairs → bits 0,1,… → fifo_level 1. Request → trng_ready for exactly 1 cycle, one cycle after request sampled; trng_data=32'h5555_5555; level 0; trng_data 0 afterwards.
2. DEBIAS_EN=0, raw 1,0 alternating 32 bits → word 32'hAAAA_AAAA. Hold request high with 3 words buffered → 3 pulses, each separated by exactly one low cycle, data in push order.
3. FIFO full: fill 4 words (W0..W3), complete a 5th → dropped, level stays 4. Four requests return W0..W3. Repeat with a pop on the push edge → 5th word kept.
4. RCT: 32 consecutive raw 1s with 2 words buffered → health_fail=1 on the 32nd-bit edge, level 0. Request held 20 cycles → no ready. health_clear → fresh word generated and served normally.
5. ChaCha-style draw: 12 sequential request/ready handshakes (8 key, 3 nonce, 1 counter) with continuous entropy → 12 pulses, no duplicate or lost words, no back-to-back pulses.
6. Assert rst while in SERVE → next cycle trng_ready=0, trng_data=0, level 0, health_fail 0, FSM IDLE.
